// File: rtl/eco32f_pipe_ctrl_pkg.sv
// eco32f_pipe_ctrl_pkg: sequencer state encodings, event kinds and exception vector helper
package eco32f_pipe_ctrl_pkg;
  localparam logic [1:0] ECO32F_PCTL_BOOT = 2'd0;
  localparam logic [1:0] ECO32F_PCTL_RUN = 2'd1;
  localparam logic [1:0] ECO32F_PCTL_DRAIN = 2'd2;
  localparam logic [4:0] ECO32F_EXC_UTLB_MISS = 5'd21;
  localparam logic [31:0] ECO32F_VEC_OFF_GEN = 32'd4;
  localparam logic [31:0] ECO32F_VEC_OFF_UTLB = 32'd8;
  typedef enum logic [1:0] {EVT_NONE, EVT_EXC, EVT_RFX, EVT_IRQ} evt_e;
  function automatic logic [31:0] vec_addr(input logic [31:0] base, input logic [4:0] cause);
    return base + (cause == ECO32F_EXC_UTLB_MISS ? ECO32F_VEC_OFF_UTLB : ECO32F_VEC_OFF_GEN);
  endfunction
endpackage

// File: rtl/eco32f_pipe_ctrl.sv
// eco32f_pipe_ctrl: per-stage stall/flush, fetch redirect arbitration and exception entry sequencing
module eco32f_pipe_ctrl
  import eco32f_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = 32'hE0000000,
  parameter logic [31:0] RAM_BASE = 32'hC0000000,
  parameter int IRQ_HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_bubble,
  input  logic        ex_div_busy,
  input  logic        mem_stall_req,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        mem_valid,
  input  logic        mem_exc,
  input  logic [4:0]  mem_exc_cause,
  input  logic        mem_op_rfx,
  input  logic [31:0] mem_pc,
  input  logic [31:0] rfx_target,
  input  logic        irq_pending,
  input  logic [4:0]  irq_cause,
  input  logic        psw_v,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        mem_flush,
  output logic        pc_redirect,
  output logic [31:0] pc_redirect_addr,
  output logic        exc_take,
  output logic [4:0]  exc_cause,
  output logic [31:0] exc_epc,
  output logic        rfx_take
);
  logic [1:0] state, state_nxt;
  evt_e lat_kind, cur_kind, kind;
  logic [4:0] lat_cause, cur_cause, cause;
  logic [31:0] lat_pc, epc;
  logic [3:0] hold;
  logic boot, run, drain, irq_ok, take, is_exc, branch, flush_all, stall_m, stall_e, latch;
  always_comb begin
    boot = state == ECO32F_PCTL_BOOT;
    run = state == ECO32F_PCTL_RUN;
    drain = state == ECO32F_PCTL_DRAIN;
    irq_ok = irq_pending & mem_valid & ~mem_exc & ~mem_op_rfx & (hold == 4'd0);
    cur_kind = (mem_valid & mem_exc) ? EVT_EXC : (mem_valid & mem_op_rfx) ? EVT_RFX :
               irq_ok ? EVT_IRQ : EVT_NONE;
    cur_cause = cur_kind == EVT_EXC ? mem_exc_cause : irq_cause;
    // In DRAIN the event captured on entry is replayed, not the live memory-stage inputs
    kind = drain ? lat_kind : run ? cur_kind : EVT_NONE;
    cause = drain ? lat_cause : cur_cause;
    epc = drain ? lat_pc : mem_pc;
    take = (kind != EVT_NONE) & ~mem_stall_req;
    is_exc = take & (kind != EVT_RFX);
    latch = run & (cur_kind != EVT_NONE) & mem_stall_req;
    stall_m = mem_stall_req | drain;
    stall_e = stall_m | ex_div_busy;
    branch = run & ex_branch_taken & ~stall_e & ~take;
    flush_all = boot | take;
    mem_flush = flush_all;
    ex_flush = flush_all;
    id_flush = flush_all | branch;
    if_flush = flush_all | branch;
    mem_stall = stall_m & ~mem_flush;
    ex_stall = stall_e & ~ex_flush;
    id_stall = stall_e & ~id_flush;
    if_stall = (stall_e | id_bubble) & ~if_flush;
    pc_redirect = flush_all | branch;
    pc_redirect_addr = boot ? ROM_BASE : ~take ? ex_branch_target :
                       kind == EVT_RFX ? rfx_target : vec_addr(psw_v ? RAM_BASE : ROM_BASE, cause);
    exc_take = is_exc;
    exc_cause = is_exc ? cause : 5'd0;
    exc_epc = is_exc ? epc : 32'd0;
    rfx_take = take & (kind == EVT_RFX);
    state_nxt = boot ? ECO32F_PCTL_RUN : (latch | (drain & mem_stall_req)) ? ECO32F_PCTL_DRAIN : ECO32F_PCTL_RUN;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ECO32F_PCTL_BOOT;
      hold <= 4'd0;
      lat_kind <= EVT_NONE;
      lat_cause <= 5'd0;
      lat_pc <= 32'd0;
    end else begin
      state <= state_nxt;
      if (is_exc) hold <= 4'(IRQ_HOLDOFF);
      else if (!ex_stall && hold != 4'd0) hold <= hold - 4'd1;
      if (latch) begin
        lat_kind <= cur_kind;
        lat_cause <= cur_cause;
        lat_pc <= mem_pc;
      end
    end
  end
endmodule

// File: tb/tb_eco32f_pipe_ctrl.sv
// tb_eco32f_pipe_ctrl: directed scenario tests with hand-computed expectations for eco32f_pipe_ctrl
module tb_eco32f_pipe_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic id_bubble, ex_div_busy, mem_stall_req, ex_branch_taken, mem_valid, mem_exc, mem_op_rfx;
  logic irq_pending, psw_v;
  logic [31:0] ex_branch_target, mem_pc, rfx_target;
  logic [4:0] mem_exc_cause, irq_cause;
  logic if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush;
  logic pc_redirect, exc_take, rfx_take;
  logic [31:0] pc_redirect_addr, exc_epc;
  logic [4:0] exc_cause;
  logic [3:0] stalls, flushes;
  int checks = 0;
  int failures = 0;
  assign stalls = {if_stall, id_stall, ex_stall, mem_stall};
  assign flushes = {if_flush, id_flush, ex_flush, mem_flush};
  always #5 clk = ~clk;
  eco32f_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_bubble(id_bubble), .ex_div_busy(ex_div_busy),
    .mem_stall_req(mem_stall_req), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .mem_valid(mem_valid), .mem_exc(mem_exc),
    .mem_exc_cause(mem_exc_cause), .mem_op_rfx(mem_op_rfx), .mem_pc(mem_pc),
    .rfx_target(rfx_target), .irq_pending(irq_pending), .irq_cause(irq_cause), .psw_v(psw_v),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr), .exc_take(exc_take),
    .exc_cause(exc_cause), .exc_epc(exc_epc), .rfx_take(rfx_take)
  );
  task automatic idle();
    id_bubble = 0; ex_div_busy = 0; mem_stall_req = 0; ex_branch_taken = 0; ex_branch_target = 0;
    mem_valid = 0; mem_exc = 0; mem_exc_cause = 0; mem_op_rfx = 0; mem_pc = 0; rfx_target = 0;
    irq_pending = 0; irq_cause = 0; psw_v = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 0;
    #1;
    checks++; if ({pc_redirect, flushes, stalls} !== 9'b1_1111_0000) begin failures++; $display("FAIL reset_ctl got %b exp 111110000", {pc_redirect, flushes, stalls}); end
    checks++; if (pc_redirect_addr !== 32'hE0000000) begin failures++; $display("FAIL reset_addr got %h exp e0000000", pc_redirect_addr); end
    checks++; if ({exc_take, rfx_take, exc_cause, exc_epc} !== 39'd0) begin failures++; $display("FAIL reset_exc got %b %b %h %h exp zeros", exc_take, rfx_take, exc_cause, exc_epc); end
    @(negedge clk); rst = 1; #1;
    checks++; if ({pc_redirect, flushes} !== 5'b1_1111 || pc_redirect_addr !== 32'hE0000000) begin failures++; $display("FAIL boot_cycle got %b %h exp 11111 e0000000", {pc_redirect, flushes}, pc_redirect_addr); end
    @(negedge clk); #1;
    checks++; if ({pc_redirect, flushes, stalls} !== 9'd0) begin failures++; $display("FAIL run_idle got %b exp 000000000", {pc_redirect, flushes, stalls}); end
  endtask
  task automatic test_exc_now();
    @(negedge clk); idle();
    mem_valid = 1; mem_exc = 1; mem_exc_cause = 5'd21; mem_pc = 32'h1000; psw_v = 1; #1;
    checks++; if ({exc_take, rfx_take, exc_cause} !== 7'b10_10101) begin failures++; $display("FAIL exc_now_take got %b %b %d exp 1 0 21", exc_take, rfx_take, exc_cause); end
    checks++; if (exc_epc !== 32'h1000 || pc_redirect_addr !== 32'hC0000008) begin failures++; $display("FAIL exc_now_addr got %h %h exp 00001000 c0000008", exc_epc, pc_redirect_addr); end
    checks++; if ({pc_redirect, flushes, stalls} !== 9'b1_1111_0000) begin failures++; $display("FAIL exc_now_ctl got %b exp 111110000", {pc_redirect, flushes, stalls}); end
    @(negedge clk); idle(); #1;
  endtask
  task automatic test_drain();
    @(negedge clk); idle();
    mem_valid = 1; mem_exc = 1; mem_exc_cause = 5'd3; mem_pc = 32'h40; mem_stall_req = 1; #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({exc_take, pc_redirect, flushes, stalls} !== 10'b00_0000_1111) begin failures++; $display("FAIL drain_hold%0d got %b exp 0000001111", i, {exc_take, pc_redirect, flushes, stalls}); end
      @(negedge clk); mem_exc_cause = 5'd7; mem_pc = 32'h44; #1;
    end
    mem_stall_req = 0; #1;
    checks++; if ({exc_take, exc_cause, exc_epc} !== {1'b1, 5'd3, 32'h40}) begin failures++; $display("FAIL drain_take got %b %d %h exp 1 3 00000040", exc_take, exc_cause, exc_epc); end
    checks++; if (pc_redirect_addr !== 32'hE0000004 || {flushes, stalls} !== 8'b1111_0000) begin failures++; $display("FAIL drain_addr got %h %b exp e0000004 11110000", pc_redirect_addr, {flushes, stalls}); end
    @(negedge clk); idle(); #1;
    checks++; if ({exc_take, pc_redirect, stalls} !== 6'd0) begin failures++; $display("FAIL drain_after got %b exp 000000", {exc_take, pc_redirect, stalls}); end
  endtask
  task automatic test_branch_rfx();
    @(negedge clk); idle();
    ex_branch_taken = 1; ex_branch_target = 32'h2000; mem_valid = 1; mem_op_rfx = 1; rfx_target = 32'h3000; #1;
    checks++; if ({rfx_take, exc_take, pc_redirect, flushes} !== 7'b101_1111 || pc_redirect_addr !== 32'h3000) begin failures++; $display("FAIL rfx_vs_branch got %b %h exp 1011111 00003000", {rfx_take, exc_take, pc_redirect, flushes}, pc_redirect_addr); end
    @(negedge clk); mem_op_rfx = 0; mem_valid = 0; #1;
    checks++; if ({rfx_take, pc_redirect, flushes} !== 6'b01_1100 || pc_redirect_addr !== 32'h2000) begin failures++; $display("FAIL branch got %b %h exp 011100 00002000", {rfx_take, pc_redirect, flushes}, pc_redirect_addr); end
    @(negedge clk); ex_div_busy = 1; #1;
    checks++; if ({pc_redirect, flushes, stalls} !== 9'b0_0000_1110) begin failures++; $display("FAIL branch_stalled got %b exp 000001110", {pc_redirect, flushes, stalls}); end
  endtask
  task automatic test_stalls();
    @(negedge clk); idle(); id_bubble = 1; #1;
    checks++; if ({flushes, stalls} !== 8'b0000_1000) begin failures++; $display("FAIL bubble got %b exp 00001000", {flushes, stalls}); end
    @(negedge clk); idle(); ex_div_busy = 1; #1;
    checks++; if ({flushes, stalls} !== 8'b0000_1110) begin failures++; $display("FAIL div_busy got %b exp 00001110", {flushes, stalls}); end
    @(negedge clk); idle(); mem_stall_req = 1; #1;
    checks++; if ({pc_redirect, flushes, stalls} !== 9'b0_0000_1111) begin failures++; $display("FAIL mem_wait got %b exp 000001111", {pc_redirect, flushes, stalls}); end
    @(negedge clk); idle(); #1;
  endtask
  task automatic test_holdoff();
    @(negedge clk); idle(); mem_valid = 1; mem_exc = 1; mem_exc_cause = 5'd5; mem_pc = 32'h500; #1;
    checks++; if (exc_take !== 1'b1) begin failures++; $display("FAIL holdoff_entry got %b exp 1", exc_take); end
    @(negedge clk); mem_exc = 0; mem_pc = 32'h600; irq_pending = 1; irq_cause = 5'd12; #1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (exc_take !== 1'b0 || pc_redirect !== 1'b0) begin failures++; $display("FAIL holdoff_c%0d got %b %b exp 0 0", i, exc_take, pc_redirect); end
      @(negedge clk); #1;
    end
    checks++; if ({exc_take, exc_cause, exc_epc} !== {1'b1, 5'd12, 32'h600} || pc_redirect_addr !== 32'hE0000004) begin failures++; $display("FAIL holdoff_irq got %b %d %h %h exp 1 12 00000600 e0000004", exc_take, exc_cause, exc_epc, pc_redirect_addr); end
    @(negedge clk); #1;
    checks++; if (exc_take !== 1'b0) begin failures++; $display("FAIL holdoff_reload got %b exp 0", exc_take); end
    @(negedge clk); idle(); #1;
  endtask
  task automatic test_async_reset();
    @(negedge clk); idle(); mem_valid = 1; mem_exc = 1; mem_exc_cause = 5'd9; mem_pc = 32'h70; mem_stall_req = 1;
    @(negedge clk); #2; rst = 0; #1;
    checks++; if ({pc_redirect, flushes, stalls, exc_take} !== 10'b1_1111_0000_0 || pc_redirect_addr !== 32'hE0000000) begin failures++; $display("FAIL async_reset got %b %h exp 1111100000 e0000000", {pc_redirect, flushes, stalls, exc_take}, pc_redirect_addr); end
    @(negedge clk); rst = 1; idle();
    @(negedge clk); #1;
    checks++; if ({exc_take, pc_redirect, stalls} !== 6'd0) begin failures++; $display("FAIL latch_cleared got %b exp 000000", {exc_take, pc_redirect, stalls}); end
  endtask
  initial begin
    test_reset();
    test_exc_now();
    test_drain();
    test_branch_rfx();
    test_stalls();
    test_holdoff();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/eco32f_pipe_ctrl.md
Name: eco32f_pipe_ctrl

Overview:
Central pipeline sequencer for the eco32f core.
- Generates per-stage stall and flush for fetch, decode, execute and memory from hazard and busy requests.
- Arbitrates redirects of the fetch PC: boot vector, taken branches from execute, and exception/interrupt/rfx entry from memory.
- Sequences exception entry, including draining an outstanding data-bus wait and an interrupt hold-off window.

Parameters:
ROM_BASE, 32'hE0000000, vector base when psw_v=0; also the boot address.
RAM_BASE, 32'hC0000000, vector base when psw_v=1.
IRQ_HOLDOFF, 4, non-stalled cycles after exception entry during which irq_pending is ignored (1..15).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
id_bubble  in  1  load/mul use hazard flagged by decode
ex_div_busy  in  1  iterative divider active in execute
mem_stall_req  in  1  data bus wait in memory stage
ex_branch_taken  in  1  execute resolves a taken branch or jump
ex_branch_target  in  32  branch/jump destination
mem_valid  in  1  memory stage holds a real (non-bubble) instruction
mem_exc  in  1  synchronous exception on the memory-stage instruction
mem_exc_cause  in  5  its cause code
mem_op_rfx  in  1  rfx instruction in memory stage
mem_pc  in  32  PC of the memory-stage instruction
rfx_target  in  32  r30 value for rfx
irq_pending  in  1  enabled interrupt pending
irq_cause  in  5  cause of the highest pending interrupt
psw_v  in  1  vector select bit
if_stall, id_stall, ex_stall, mem_stall  out  1 each  hold the stage register
if_flush, id_flush, ex_flush, mem_flush  out  1 each  load a no-op into the stage register
pc_redirect  out  1  fetch loads pc_redirect_addr this cycle
pc_redirect_addr  out  32  new fetch PC
exc_take  out  1  one-cycle pulse: save PSW/EPC, enter handler
exc_cause  out  5  cause qualified by exc_take
exc_epc  out  32  EPC qualified by exc_take
rfx_take  out  1  one-cycle pulse: restore PSW

Behaviour:
FSM states:
- BOOT (reset state).
  - Outputs pc_redirect=1, pc_redirect_addr=ROM_BASE, all flushes=1, all stalls=0.
  - Next state is RUN.
- RUN.
  - An event is any of: mem_valid&mem_exc, mem_valid&mem_op_rfx, or irq_ok = irq_pending & mem_valid & !mem_exc & !mem_op_rfx & holdoff counter==0.
  - Priority: exception > rfx > irq.
  - On an event with mem_stall_req=0: take the event this cycle, combinationally.
  - On an event with mem_stall_req=1: latch kind, cause and mem_pc; go to DRAIN.
- DRAIN.
  - mem_stall forced to 1, so all stages stall.
  - When mem_stall_req=0: take the latched event in that cycle. Next state is RUN.

Taking an event:
- if/id/ex/mem_flush=1 and pc_redirect=1. The memory-stage instruction is killed; for rfx it has no writeback.
- Exception/irq:
  - exc_take=1, exc_cause=cause, exc_epc=mem_pc.
  - addr = (psw_v ? RAM_BASE : ROM_BASE) + (cause==21 ? 8 : 4).
  - Holdoff counter loads IRQ_HOLDOFF.
- rfx: rfx_take=1, addr=rfx_target.

Taken branch:
- Condition: ex_branch_taken & !ex_stall, with no event taken this cycle.
- Response: pc_redirect=1, addr=ex_branch_target, if_flush=id_flush=1. No delay slot.
- An event taken the same cycle wins; the branch is discarded.

Stalls (when no flush):
- mem_stall = mem_stall_req | (state==DRAIN)
- ex_stall = mem_stall | ex_div_busy
- id_stall = ex_stall
- if_stall = id_stall | id_bubble (decode itself inserts the bubble no-op)

Flush/stall interaction:
- A flush overrides the stall of the same stage; the stage register loads a no-op.
- A stage's stall output is 0 whenever its flush output is 1.

Holdoff counter:
- 4 bits; decrements on cycles where ex_stall=0 and it is nonzero.
- Saturates at 0.
- Reset value 0.

Reset:
- Asynchronous, mid-operation included: state=BOOT, holdoff=0, latched event cleared.
- Output reset values are the BOOT values above.
- exc_take=rfx_take=0, exc_cause=0, exc_epc=0.

All redirect, flush and pulse outputs are combinational from state and inputs (zero latency); only state, latch and counter are registered.

Decomposition:
- eco32f.vh gains:
  - ECO32F_PCTL_BOOT/RUN/DRAIN state encodings (2 bits);
  - ECO32F_EXC_UTLB_MISS=5'd21;
  - ECO32F_VEC_OFF_GEN=4 and ECO32F_VEC_OFF_UTLB=8.
- No sub-module. The holdoff counter and event latch are inline.

Test Plan:
- Release rst -> first cycle pc_redirect=1, addr=32'hE0000000, all flush=1; second cycle state RUN, all flush=0.
- mem_valid=1, mem_exc=1, cause=5'd21, mem_pc=32'h1000, psw_v=1 -> same cycle exc_take=1, exc_epc=32'h1000, addr=32'hC0000008, if/id/ex/mem_flush=1.
- mem_exc=1 with mem_stall_req=1 for 3 cycles -> all stalls=1 and no exc_take for 3 cycles; exc_take on cycle 4 with cause/epc latched at entry.
- ex_branch_taken=1, target=32'h2000, mem_op_rfx=1, rfx_target=32'h3000 in the same cycle -> rfx_take=1, addr=32'h3000, branch ignored.
- id_bubble=1 alone -> if_stall=1, id_stall=0, no flush; ex_div_busy=1 -> ex/id/if_stall=1, mem_stall=0.
- Exception taken, then irq_pending=1 held -> no exc_take for 4 non-stalled cycles (IRQ_HOLDOFF=4); taken on cycle 5 with exc_cause=irq_cause, addr=ROM_BASE+4 when psw_v=0.
